// File: rtl/cam_lookup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_lookup_ctrl_pkg
//  Description : Shared types and constants for the CAM lookup controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_lookup_ctrl_pkg;

  // Cycles between presenting a compare key and the CAM result being valid.
  localparam int CAM_LATENCY = 1;

  localparam int STAT_WIDTH = 32;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_WRITE  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cam_result_fifo
//  Description : Lookup result FIFO (tag, hit, addr). Power-of-two depth,
//                push and pop in the same cycle are allowed even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_result_fifo #(
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [TAG_WIDTH-1:0]    push_tag,
  input  logic                    push_hit,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic                    pop,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_hit,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic                    out_valid,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = TAG_WIDTH + 1 + ADDR_WIDTH;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for storage, pointers (natural modulo-DEPTH wrap) and fill level.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {push_tag, push_hit, push_addr};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = (count_q != '0);
  assign count     = count_q;
  // Data fields read as zero whenever nothing is presented.
  assign {out_tag, out_hit, out_addr} = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cam_lookup_ctrl
//  Description : Pipelined CAM lookup controller with result FIFO, hit/miss
//                statistics and a drain-write-settle control-plane path.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_lookup_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_key_data,
  input  logic [TAG_WIDTH-1:0]  s_key_tag,
  input  logic                  s_key_valid,
  output logic                  s_key_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_delete,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [TAG_WIDTH-1:0]  m_res_tag,
  output logic                  m_res_hit,
  output logic [ADDR_WIDTH-1:0] m_res_addr,
  output logic                  m_res_valid,
  input  logic                  m_res_ready,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);

  import cam_lookup_ctrl_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;
  logic [DATA_WIDTH-1:0] cmp_data_q, cmp_data_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_delete_q, wr_delete_d;
  logic [31:0]           hits_q, hits_d;
  logic [31:0]           misses_q, misses_d;

  logic [CNT_W-1:0]      fifo_count;
  logic [1:0]            inflight;
  logic [OCC_W-1:0]      occupancy;
  logic                  key_ready;
  logic                  key_accept;
  logic                  write_fire;
  logic                  res_push;
  logic                  res_pop;
  logic [ADDR_WIDTH-1:0] res_addr;

  // Lookups in the two pipeline stages each own a reserved FIFO slot, so the
  // result can always be pushed without checking for space.
  assign inflight   = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
  assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign key_ready  = (state_q == ST_RUN) && !cfg_valid && (occupancy < OCC_LIMIT);
  assign key_accept = s_key_valid && key_ready;

  // FSM next state: a config request drains the pipeline, waits for the CAM,
  // writes once and gives the CAM one settle cycle before lookups resume.
  always_comb begin
    state_d    = state_q;
    write_fire = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (inflight == 2'd0) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!cam_write_busy) begin
          write_fire = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Lookup pipeline next values: stage 1 holds the compare key, stage 2
  // lines up the tag with the CAM result.
  always_comb begin
    s1_valid_d = key_accept;
    s1_tag_d   = key_accept ? s_key_tag  : s1_tag_q;
    cmp_data_d = key_accept ? s_key_data : cmp_data_q;
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
  end

  // Lookup pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      cmp_data_q <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      cmp_data_q <= cmp_data_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  // Capture the config request when it is taken in RUN.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_delete_d = wr_delete_q;
    if ((state_q == ST_RUN) && cfg_valid) begin
      wr_addr_d   = cfg_addr;
      wr_data_d   = cfg_data;
      wr_delete_d = cfg_delete;
    end
  end

  // Pending config write registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_delete_q <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_delete_q <= wr_delete_d;
    end
  end

  assign res_push = s2_valid_q;
  assign res_addr = cam_match ? cam_match_addr : '0;
  assign res_pop  = m_res_valid && m_res_ready;

  // Hit/miss statistics advance on each result push and saturate.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (res_push) begin
      if (cam_match) hits_d   = sat_inc(hits_q);
      else           misses_d = sat_inc(misses_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  cam_result_fifo #(
    .TAG_WIDTH  (TAG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_tag  (s2_tag_q),
    .push_hit  (cam_match),
    .push_addr (res_addr),
    .pop       (res_pop),
    .out_tag   (m_res_tag),
    .out_hit   (m_res_hit),
    .out_addr  (m_res_addr),
    .out_valid (m_res_valid),
    .count     (fifo_count)
  );

  // Handshake pulses are masked by reset so an interrupted write never fires.
  assign s_key_ready      = key_ready && !rst;
  assign cam_write_enable = write_fire && !rst;
  assign cfg_ready        = write_fire && !rst;
  assign cam_write_addr   = wr_addr_q;
  assign cam_write_data   = wr_data_q;
  assign cam_write_delete = wr_delete_q;
  assign cam_compare_data = cmp_data_q;
  assign stat_hits        = hits_q;
  assign stat_misses      = misses_q;

endmodule
`default_nettype wire

// File: doc/cam_lookup_ctrl.md
CAM_LOOKUP_CTRL -- requirements
Module: cam_lookup_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, key width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, CAM index width (2**ADDR_WIDTH entries).
REQ-003 SHALL have parameter TAG_WIDTH, default 8, opaque per-lookup tag.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >=4).
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports s_key_data/s_key_tag/s_key_valid  in  DATA_WIDTH/TAG_WIDTH/1  lookup request.
REQ-008 SHALL have port s_key_ready  out  1  request accepted on valid&ready.
REQ-009 SHALL have ports cfg_addr/cfg_data/cfg_delete/cfg_valid  in  ADDR_WIDTH/DATA_WIDTH/1/1  control-plane CAM write.
REQ-010 SHALL have port cfg_ready  out  1  one-cycle pulse when cfg write issued.
REQ-011 SHALL have ports cam_write_addr/cam_write_data/cam_write_delete/cam_write_enable  out  ADDR_WIDTH/DATA_WIDTH/1/1  to CAM.
REQ-012 SHALL have port cam_write_busy  in  1  CAM cannot take write.
REQ-013 SHALL have port cam_compare_data  out  DATA_WIDTH  registered key to CAM.
REQ-014 SHALL have ports cam_match/cam_match_addr  in  1/ADDR_WIDTH  CAM result, valid exactly 1 cycle after compare_data presented.
REQ-015 SHALL have ports m_res_tag/m_res_hit/m_res_addr/m_res_valid  out  TAG_WIDTH/1/ADDR_WIDTH/1  lookup result.
REQ-016 SHALL have port m_res_ready  in  1  result consumed on valid&ready.
REQ-017 SHALL have ports stat_hits/stat_misses  out  32/32  saturating counters.

Function
REQ-018 Accept at cycle T SHALL load cam_compare_data and tag into stage-1 register (valid during T+1); CAM result sampled at end of T+2 into stage-2/FIFO; m_res_valid SHALL assert at T+3 when FIFO empty.
REQ-019 Back-to-back accepts SHALL sustain one lookup per cycle; results SHALL leave in acceptance order.
REQ-020 s_key_ready SHALL be high only in RUN and when FIFO free entries minus in-flight lookups (0..2) > 0; no result SHALL ever be dropped.
REQ-021 m_res_hit = cam_match, m_res_addr = cam_match_addr on hit, 0 on miss.
REQ-022 FIFO SHALL support simultaneous push and pop when full; pointers wrap modulo FIFO_DEPTH.
REQ-023 stat_hits/stat_misses SHALL increment on FIFO push per hit/miss and hold at 0xFFFFFFFF.
REQ-024 FSM states RUN, DRAIN, WRITE, SETTLE; RUN->DRAIN when cfg_valid (s_key_ready low from same cycle).
REQ-025 DRAIN->WRITE when in-flight count = 0 (FIFO contents need not drain).
REQ-026 WRITE: when cam_write_busy low, assert cam_write_enable one cycle with cfg fields, pulse cfg_ready, go SETTLE; hold otherwise.
REQ-027 SETTLE: one cycle, then RUN; first key accepted after SETTLE SHALL see the new entry.
REQ-028 A cfg write SHALL win over a key offered in the same cycle in RUN.

Reset
REQ-029 On rst: FSM=RUN, FIFO empty, in-flight=0, m_res_valid=0, s_key_ready=0 during reset, cfg_ready=0, cam_write_enable=0, cam_compare_data=0, stats=0; outputs data fields 0.
REQ-030 Reset mid-lookup or mid-write SHALL discard in-flight lookups and pending write with no cfg_ready pulse.

Structure
REQ-031 Shared package SHALL hold FSM state enum and CAM_LATENCY=1 constant.
REQ-032 Result FIFO SHALL be sub-module cam_result_fifo (tag, hit, addr).

Verification
REQ-033 Write key 0xAA at addr 3, lookup 0xAA tag 0x11 -> m_res hit=1 addr=3 tag=0x11 at T+3.
REQ-034 Lookup unknown key 0x55 -> hit=0 addr=0; stat_misses=1.
REQ-035 8 back-to-back lookups, m_res_ready=0 -> s_key_ready drops after 4 accepted; release ready -> all 8 results in order, none lost.
REQ-036 cfg_valid with 2 lookups in flight, cam_write_busy=1 for 3 cycles -> both results delivered, write issued after busy drops, cfg_ready single pulse.
REQ-037 Delete addr 3 then lookup 0xAA immediately after SETTLE -> hit=0.
REQ-038 Assert rst during WRITE -> cam_write_enable never asserted, all outputs at reset values next cycle.
